// File: rtl/cmp_operand_loader.sv
// cmp_operand_loader
// Front end for a combinational W-bit magnitude comparator. It collects both
// operands as 2-bit digits, MSB first, from a valid/ready stream and holds the
// assembled words on the comparator inputs. It then samples the comparator's
// g/e outputs once and offers them as a registered valid/ready result.
//
// Parameters
//   W          operand width in bits (even, >= 4); N = W/2 digits per operand
// Ports
//   clk, rst   rising-edge clock, synchronous active-high reset
//   flush      synchronous abort of the current transaction (res_cnt kept)
//   in_valid / in_ready / a_dig / b_dig   digit-pair input stream
//   cmp_a / cmp_b                         assembled operands to the comparator
//   cmp_g / cmp_e                         comparator results
//   res_valid / res_ready / res_g / res_e result stream
//   res_cnt    results delivered since reset, wraps at 256
module cmp_operand_loader #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   a_dig,
    input  logic [1:0]   b_dig,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_g,
    input  logic         cmp_e,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_g,
    output logic         res_e,
    output logic [7:0]   res_cnt
);

    localparam int unsigned N  = W / 2;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [W-1:0]   a_sh, a_sh_d;
    logic [W-1:0]   b_sh, b_sh_d;
    logic [CW-1:0]  dcnt, dcnt_d;
    logic           res_g_d, res_e_d, res_valid_d;
    logic [7:0]     res_cnt_d;

    // Accept digits only while loading; depends on state alone.
    assign in_ready = (state == LOAD);

    // Comparator inputs come straight from the shift registers.
    assign cmp_a = a_sh;
    assign cmp_b = b_sh;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            a_sh      <= '0;
            b_sh      <= '0;
            dcnt      <= '0;
            res_g     <= 1'b0;
            res_e     <= 1'b0;
            res_valid <= 1'b0;
            res_cnt   <= 8'd0;
        end else begin
            state     <= state_d;
            a_sh      <= a_sh_d;
            b_sh      <= b_sh_d;
            dcnt      <= dcnt_d;
            res_g     <= res_g_d;
            res_e     <= res_e_d;
            res_valid <= res_valid_d;
            res_cnt   <= res_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state;
        a_sh_d      = a_sh;
        b_sh_d      = b_sh;
        dcnt_d      = dcnt;
        res_g_d     = res_g;
        res_e_d     = res_e;
        res_valid_d = res_valid;
        res_cnt_d   = res_cnt;

        if (flush) begin
            // Abort: drop any digit this cycle and discard a held result uncounted.
            state_d     = LOAD;
            a_sh_d      = '0;
            b_sh_d      = '0;
            dcnt_d      = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        a_sh_d = {a_sh[W-3:0], a_dig};
                        b_sh_d = {b_sh[W-3:0], b_dig};
                        if (dcnt == CW'(N - 1)) begin
                            dcnt_d  = '0;
                            state_d = SAMPLE;
                        end else begin
                            dcnt_d = dcnt + CW'(1);
                        end
                    end
                end
                SAMPLE: begin
                    // Operands have been stable for a full cycle; capture once.
                    res_g_d     = cmp_g;
                    res_e_d     = cmp_e;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        res_cnt_d   = res_cnt + 8'd1;
                        state_d     = LOAD;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Testbench for cmp_operand_loader: directed scenarios plus a randomized run,
// checked every cycle against a transaction-level model, and a W=4 instance.
module tb_cmp_operand_loader;

    localparam int unsigned W   = 10;
    localparam int unsigned N   = W / 2;
    localparam int          MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready;
    logic [1:0]   a_dig, b_dig;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_g, cmp_e;
    logic         res_valid, res_ready, res_g, res_e;
    logic [7:0]   res_cnt;

    // Second instance at the minimum width.
    logic         flush4, in4_valid, in4_ready;
    logic [1:0]   a4_dig, b4_dig;
    logic [3:0]   c4a, c4b;
    logic         c4g, c4e;
    logic         r4_valid, r4_ready, r4_g, r4_e;
    logic [7:0]   r4_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cmp_operand_loader #(.W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_dig(a_dig), .b_dig(b_dig),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_g(cmp_g), .cmp_e(cmp_e),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_g(res_g), .res_e(res_e), .res_cnt(res_cnt)
    );

    cmp_operand_loader #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4),
        .in_valid(in4_valid), .in_ready(in4_ready),
        .a_dig(a4_dig), .b_dig(b4_dig),
        .cmp_a(c4a), .cmp_b(c4b),
        .cmp_g(c4g), .cmp_e(c4e),
        .res_valid(r4_valid), .res_ready(r4_ready),
        .res_g(r4_g), .res_e(r4_e), .res_cnt(r4_cnt)
    );

    // Real comparator behind the small instance.
    assign c4g = (c4a > c4b);
    assign c4e = (c4a == c4b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one active edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] a, input logic [1:0] b, input int gap);
        in_valid = 1'b1;
        a_dig    = a;
        b_dig    = b;
        step();
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    // Transaction-level model: operand values as integers, digits counted,
    // a pending-sample flag, and the offered result.
    int m_ok = 0;
    int m_a = 0, m_b = 0, m_k = 0, m_samp = 0, m_rv = 0, m_g = 0, m_e = 0, m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1; m_a = 0; m_b = 0; m_k = 0; m_samp = 0;
            m_rv = 0; m_g = 0; m_e = 0; m_cnt = 0;
        end else if (flush) begin
            m_a = 0; m_b = 0; m_k = 0; m_samp = 0; m_rv = 0;
        end else if (m_rv != 0) begin
            if (res_ready) begin
                m_rv  = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
        end else if (m_samp != 0) begin
            m_samp = 0;
            m_rv   = 1;
            m_g    = int'(cmp_g);
            m_e    = int'(cmp_e);
        end else if (in_valid) begin
            m_a = (m_a * 4 + int'(a_dig)) % MOD;
            m_b = (m_b * 4 + int'(b_dig)) % MOD;
            m_k = m_k + 1;
            if (m_k == N) begin
                m_k    = 0;
                m_samp = 1;
            end
        end
        #1;
        if (m_ok != 0) begin
            chk("m_in_ready",  32'(in_ready),  32'((m_rv == 0 && m_samp == 0) ? 1 : 0));
            chk("m_res_valid", 32'(res_valid), 32'(m_rv));
            chk("m_res_g",     32'(res_g),     32'(m_g));
            chk("m_res_e",     32'(res_e),     32'(m_e));
            chk("m_res_cnt",   32'(res_cnt),   32'(m_cnt));
            chk("m_cmp_a",     32'(cmp_a),     32'(m_a));
            chk("m_cmp_b",     32'(cmp_b),     32'(m_b));
        end
    end

    initial begin
        // Reset with random inputs applied.
        rst       = 1'b1;
        flush     = 1'($urandom);
        in_valid  = 1'($urandom);
        a_dig     = 2'($urandom);
        b_dig     = 2'($urandom);
        cmp_g     = 1'($urandom);
        cmp_e     = 1'($urandom);
        res_ready = 1'($urandom);
        flush4    = 1'b0;
        in4_valid = 1'b0;
        a4_dig    = 2'd0;
        b4_dig    = 2'd0;
        r4_ready  = 1'b1;
        step();
        step();
        chk("rst_cmp_a", 32'(cmp_a), 32'd0);
        chk("rst_cmp_b", 32'(cmp_b), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_g", 32'(res_g), 32'd0);
        chk("rst_res_e", 32'(res_e), 32'd0);
        chk("rst_res_cnt", 32'(res_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        cmp_g = 1'b1; cmp_e = 1'b0;

        // Reset while a result is held.
        for (int i = 0; i < int'(N); i++) send(2'd1, 2'd0, 0);
        step();
        step();
        chk("hold_before_rst", 32'(res_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hold_rst_valid", 32'(res_valid), 32'd0);
        chk("hold_rst_cnt", 32'(res_cnt), 32'd0);
        chk("hold_rst_ready", 32'(in_ready), 32'd1);

        // Equal operands 700/700, back-to-back digits.
        cmp_g = 1'b0; cmp_e = 1'b1; res_ready = 1'b1;
        send(2'd2, 2'd2, 0);
        send(2'd2, 2'd2, 0);
        send(2'd3, 2'd3, 0);
        send(2'd3, 2'd3, 0);
        send(2'd0, 2'd0, 0);
        chk("eq_cmp_a", 32'(cmp_a), 32'd700);
        chk("eq_cmp_b", 32'(cmp_b), 32'd700);
        chk("eq_valid_early", 32'(res_valid), 32'd0);
        chk("eq_in_ready_sample", 32'(in_ready), 32'd0);
        step();
        chk("eq_valid", 32'(res_valid), 32'd1);
        chk("eq_g", 32'(res_g), 32'd0);
        chk("eq_e", 32'(res_e), 32'd1);
        step();
        chk("eq_cnt", 32'(res_cnt), 32'd1);
        chk("eq_valid_drop", 32'(res_valid), 32'd0);
        chk("eq_in_ready_back", 32'(in_ready), 32'd1);

        // 0x3FF vs 0x001 with 3-cycle gaps and 10 cycles of backpressure.
        cmp_g = 1'b1; cmp_e = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 2'd0, 3);
        send(2'd3, 2'd1, 0);
        chk("bp_cmp_a", 32'(cmp_a), 32'h3FF);
        chk("bp_cmp_b", 32'(cmp_b), 32'h001);
        in_valid = 1'b1; a_dig = 2'd1; b_dig = 2'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_g", 32'(res_g), 32'd1);
            chk("bp_e", 32'(res_e), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_a", 32'(cmp_a), 32'h3FF);
        end
        in_valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_cnt", 32'(res_cnt), 32'd2);
        res_ready = 1'b1;
        repeat (3) step();
        res_ready = 1'b0;
        chk("bp_single_handshake", 32'(res_cnt), 32'd2);

        // Flush after three digits, then a clean load.
        send(2'd1, 2'd2, 0);
        send(2'd2, 2'd1, 0);
        send(2'd3, 2'd3, 0);
        flush = 1'b1; in_valid = 1'b1; a_dig = 2'd3; b_dig = 2'd3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_cmp_a", 32'(cmp_a), 32'd0);
        chk("fl_cmp_b", 32'(cmp_b), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b1;
        send(2'd1, 2'd0, 0);
        send(2'd0, 2'd0, 0);
        send(2'd0, 2'd0, 0);
        send(2'd0, 2'd0, 0);
        chk("fl_no_early_sample", 32'(in_ready), 32'd1);
        send(2'd0, 2'd2, 0);
        chk("fl_new_a", 32'(cmp_a), 32'd256);
        chk("fl_new_b", 32'(cmp_b), 32'd2);
        step();
        chk("fl_valid", 32'(res_valid), 32'd1);
        repeat (6) step();
        chk("fl_one_result", 32'(res_cnt), 32'd3);

        // W=4 instance: a=0xB (2,3), b=0x4 (1,0).
        in4_valid = 1'b1; a4_dig = 2'd2; b4_dig = 2'd1;
        step();
        a4_dig = 2'd3; b4_dig = 2'd0;
        step();
        in4_valid = 1'b0;
        chk("w4_cmp_a", 32'(c4a), 32'hB);
        chk("w4_cmp_b", 32'(c4b), 32'h4);
        chk("w4_valid_early", 32'(r4_valid), 32'd0);
        step();
        chk("w4_valid", 32'(r4_valid), 32'd1);
        chk("w4_g", 32'(r4_g), 32'd1);
        chk("w4_e", 32'(r4_e), 32'd0);

        // 256 back-to-back transactions at 7 cycles each wrap the counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1; a_dig = 2'd1; b_dig = 2'd3; res_ready = 1'b1;
        repeat (256 * 7 - 1) step();
        chk("wrap_cnt_255", 32'(res_cnt), 32'd255);
        chk("wrap_valid_last", 32'(res_valid), 32'd1);
        step();
        chk("wrap_cnt_0", 32'(res_cnt), 32'd0);
        chk("wrap_valid_done", 32'(res_valid), 32'd0);
        in_valid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(299) == 0);
            flush     = ($urandom_range(39) == 0);
            in_valid  = ($urandom_range(3) != 0);
            a_dig     = 2'($urandom);
            b_dig     = 2'($urandom);
            cmp_g     = 1'($urandom);
            cmp_e     = 1'($urandom);
            res_ready = ($urandom_range(2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
